// File: rtl/spi_mcp4822_dac_pkg.sv
// Shared types and frame layout for the MCP4822 DAC SPI transmitter.
// SPI_MCP4822_STEREO_EN adds the inter-frame gap state used for A/B stereo pairs.
package dac_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CH_BIT     = 15;
  localparam int GA_BIT     = 13;
  localparam int SHDN_BIT   = 12;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LDAC,
    GAP
`ifdef SPI_MCP4822_STEREO_EN
    , GAP_AB
`endif
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bit 14 is the "don't care" bit of the MCP4822 command and is sent as 0.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic ch, input logic ga,
                                                       input logic [11:0] code);
    logic [FRAME_BITS-1:0] f;
    f           = '0;
    f[CH_BIT]   = ch;
    f[GA_BIT]   = ga;
    f[SHDN_BIT] = 1'b1;
    f[11:0]     = code;
    return f;
  endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// SCK generator: toggles sck every CLK_DIV enabled cycles, pulsing rise/fall ticks one cycle ahead
// of the edge they announce; disabling it returns the count to 0 and sck low with no backpressure.
module spi_clk_tick #(
  parameter int CLK_DIV = 4,
  parameter int CW      = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);

  logic [CW-1:0] cnt;
  logic          term;

  assign term      = (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = en & term & ~sck;
  assign fall_tick = en & term & sck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (term) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_mcp4822_dac.sv
// MCP4822 SPI master (mode 0); SPI_MCP4822_STEREO_EN sends A then B frames per sample with one LDAC.
// Ready again 32*CLK_DIV+LDAC_CYCLES+CS_HIGH_CYCLES cycles after accept; sample_ready low while busy.
module spi_mcp4822_dac
  import dac_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int LDAC_CYCLES    = 2,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_valid,
  output logic        sample_ready,
`ifdef SPI_MCP4822_STEREO_EN
  input  logic [23:0] sample_data,
`else
  input  logic [11:0] sample_data,
`endif
  input  logic        sample_channel,
  input  logic        gain_1x,
  output logic        dac_sck,
  output logic        dac_cs_n,
  output logic        dac_mosi,
  output logic        dac_ldac_n,
  output logic        busy
);

  localparam int            CW        = $clog2(max3(CLK_DIV, LDAC_CYCLES, CS_HIGH_CYCLES)) + 1;
  localparam logic [CW-1:0] LDAC_LAST = CW'(LDAC_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(CS_HIGH_CYCLES - 1);

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg, frame_a;
  logic                  shift_en, rise_tick_unused, fall_tick, last_fall, accept;

`ifdef SPI_MCP4822_STEREO_EN
  logic [11:0]           data_b;
  logic                  gain_q, second;
  logic [FRAME_BITS-1:0] frame_b;
  logic                  channel_unused;

  assign channel_unused = sample_channel;
  assign frame_a        = make_frame(1'b0, gain_1x, sample_data[11:0]);
  assign frame_b        = make_frame(1'b1, gain_q, data_b);
`else
  assign frame_a        = make_frame(sample_channel, gain_1x, sample_data);
`endif

  assign accept    = sample_valid & sample_ready;
  assign shift_en  = (state == SHIFT);
  assign last_fall = fall_tick & (bit_cnt == 4'd15);

  spi_clk_tick #(
    .CLK_DIV (CLK_DIV),
    .CW      (CW)
  ) u_tick (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (shift_en),
    .sck       (dac_sck),
    .rise_tick (rise_tick_unused),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (last_fall) begin
`ifdef SPI_MCP4822_STEREO_EN
          state_nxt = second ? LDAC : GAP_AB;
`else
          state_nxt = LDAC;
`endif
        end
      end
      LDAC:  if (cnt == LDAC_LAST) state_nxt = GAP;
      GAP:   if (cnt == GAP_LAST) state_nxt = IDLE;
`ifdef SPI_MCP4822_STEREO_EN
      GAP_AB: if (cnt == GAP_LAST) state_nxt = SHIFT;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and strobe flops follow the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_ready <= 1'b1;
      busy         <= 1'b0;
      dac_cs_n     <= 1'b1;
      dac_mosi     <= 1'b0;
      dac_ldac_n   <= 1'b1;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
`ifdef SPI_MCP4822_STEREO_EN
      data_b       <= '0;
      gain_q       <= 1'b0;
      second       <= 1'b0;
`endif
    end else begin
      sample_ready <= (state_nxt == IDLE);
      busy         <= (state_nxt != IDLE);
      dac_ldac_n   <= (state_nxt != LDAC);
      cnt          <= (state_nxt != state) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg    <= frame_a;
            dac_mosi <= frame_a[FRAME_BITS-1];
            dac_cs_n <= 1'b0;
            bit_cnt  <= '0;
`ifdef SPI_MCP4822_STEREO_EN
            data_b   <= sample_data[23:12];
            gain_q   <= gain_1x;
            second   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (fall_tick) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (last_fall) begin
              dac_cs_n <= 1'b1;
              dac_mosi <= 1'b0;
            end else begin
              dac_mosi <= shreg[FRAME_BITS-2];
              shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
`ifdef SPI_MCP4822_STEREO_EN
        GAP_AB: begin
          if (cnt == GAP_LAST) begin
            shreg    <= frame_b;
            dac_mosi <= frame_b[FRAME_BITS-1];
            dac_cs_n <= 1'b0;
            second   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mcp4822_dac.sv
// Directed bench for spi_mcp4822_dac: decodes frames off the SPI pins and checks timing and handshake.
module tb_spi_mcp4822_dac;

  localparam int CLK_DIV        = 2;
  localparam int LDAC_CYCLES    = 2;
  localparam int CS_HIGH_CYCLES = 4;
`ifdef SPI_MCP4822_STEREO_EN
  localparam int DW = 24;
`else
  localparam int DW = 12;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sample_valid;
  logic          sample_ready;
  logic [DW-1:0] sample_data;
  logic          sample_channel;
  logic          gain_1x;
  logic          dac_sck, dac_cs_n, dac_mosi, dac_ldac_n, busy;

  spi_mcp4822_dac #(
    .CLK_DIV        (CLK_DIV),
    .LDAC_CYCLES    (LDAC_CYCLES),
    .CS_HIGH_CYCLES (CS_HIGH_CYCLES)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .sample_data    (sample_data),
    .sample_channel (sample_channel),
    .gain_1x        (gain_1x),
    .dac_sck        (dac_sck),
    .dac_cs_n       (dac_cs_n),
    .dac_mosi       (dac_mosi),
    .dac_ldac_n     (dac_ldac_n),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] frames[$];
  int          nbits_q[$], cslow_q[$], csrise_q[$], ldacfall_q[$], ldaclen_q[$], rdyrise_q[$], acc_q[$];
  logic [15:0] cap = '0;
  int          bits = 0, cs_run = 0, ldac_run = 0;
  logic        sck_p = 1'b0, cs_p = 1'b1, ldac_p = 1'b1, rdy_p = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Edge numbering: cyc is the index of the most recent rising clk edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset_n && sample_valid && sample_ready) acc_q.push_back(cyc);
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      cap = '0; bits = 0; cs_run = 0; ldac_run = 0;
      sck_p = 1'b0; cs_p = 1'b1; ldac_p = 1'b1; rdy_p = 1'b1;
    end else begin
      if (dac_sck && !sck_p) begin
        cap  = {cap[14:0], dac_mosi};
        bits = bits + 1;
      end
      if (!dac_cs_n) cs_run = cs_run + 1;
      if (dac_cs_n && !cs_p) begin
        frames.push_back(cap);
        nbits_q.push_back(bits);
        cslow_q.push_back(cs_run);
        csrise_q.push_back(cyc);
        cap = '0; bits = 0; cs_run = 0;
      end
      if (!dac_ldac_n) ldac_run = ldac_run + 1;
      if (!dac_ldac_n && ldac_p) ldacfall_q.push_back(cyc);
      if (dac_ldac_n && !ldac_p) begin
        ldaclen_q.push_back(ldac_run);
        ldac_run = 0;
      end
      if (sample_ready && !rdy_p) rdyrise_q.push_back(cyc);
      n_assert++;
      assert (sample_ready === ~busy)
      else begin
        n_fail++;
        $error("FAIL ready_busy_complement: ready=%b busy=%b at edge %0d", sample_ready, busy, cyc);
      end
      sck_p = dac_sck; cs_p = dac_cs_n; ldac_p = dac_ldac_n; rdy_p = sample_ready;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] d, input logic ch, input logic ga);
    tick();
    sample_valid   = 1'b1;
    sample_data    = d[DW-1:0];
    sample_channel = ch;
    gain_1x        = ga;
    tick();
    sample_valid   = 1'b0;
  endtask

  task automatic wait_done(input int nframes, input string tag);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      tick();
      if (frames.size() >= nframes && sample_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(sample_ready), 32'd1);
    chk({tag, "_busy"},  32'(busy),         32'd0);
    chk({tag, "_sck"},   32'(dac_sck),      32'd0);
    chk({tag, "_cs_n"},  32'(dac_cs_n),     32'd1);
    chk({tag, "_mosi"},  32'(dac_mosi),     32'd0);
    chk({tag, "_ldac"},  32'(dac_ldac_n),   32'd1);
  endtask

  initial begin
    int          base_f, base_a, base_l;
    int          idx;
    logic        ok;
    logic [11:0] hd[3]  = '{12'h111, 12'h222, 12'h333};
    logic        hch[3] = '{1'b0, 1'b1, 1'b1};
    logic        hga[3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] hex[3] = '{16'h3111, 16'h9222, 16'hB333};

    reset_n        = 1'b0;
    sample_valid   = 1'b0;
    sample_data    = '0;
    sample_channel = 1'b0;
    gain_1x        = 1'b0;
    repeat (3) tick();
    check_reset_values("in_reset");
    reset_n = 1'b1;
    repeat (2) tick();
    check_reset_values("after_reset");

`ifdef SPI_MCP4822_STEREO_EN
    base_f = frames.size();
    base_l = ldacfall_q.size();
    send(24'h123456, 1'b0, 1'b1);
    wait_done(base_f + 2, "stereo");
    chk("stereo_frame_a", 32'(frames[base_f]),     32'h3456);
    chk("stereo_frame_b", 32'(frames[base_f + 1]), 32'hB123);
    chk("stereo_ldac_count", 32'(ldacfall_q.size() - base_l), 32'd1);
    chk("stereo_ldac_after_b", 32'(ldacfall_q[$]), 32'(csrise_q[base_f + 1]));
    chk("stereo_latency", 32'(rdyrise_q[$] - acc_q[$]), 32'd138);
`else
    // Reference frame 0xABC on channel B at 1x gain.
    base_f = frames.size();
    send(24'hABC, 1'b1, 1'b1);
    wait_done(base_f + 1, "frame_abc");
    chk("frame_abc_word",    32'(frames[$]),  32'hBABC);
    chk("frame_abc_bits",    32'(nbits_q[$]), 32'd16);
    chk("frame_abc_cs_low",  32'(cslow_q[$]), 32'd64);
    chk("frame_abc_ldac",    32'(ldaclen_q[$]), 32'd2);
    chk("frame_abc_ldac_at", 32'(ldacfall_q[$] - csrise_q[$]), 32'd0);
    chk("frame_abc_latency", 32'(rdyrise_q[$] - acc_q[$]), 32'd70);

    send(24'h000, 1'b0, 1'b0);
    wait_done(base_f + 2, "frame_zero");
    chk("frame_zero_word", 32'(frames[$]), 32'h1000);

    send(24'hFFF, 1'b0, 1'b1);
    wait_done(base_f + 3, "frame_full");
    chk("frame_full_word", 32'(frames[$]), 32'h3FFF);

    // Valid held high across three back-to-back samples.
    base_f = frames.size();
    base_a = acc_q.size();
    tick();
    idx            = 0;
    sample_valid   = 1'b1;
    sample_data    = hd[0];
    sample_channel = hch[0];
    gain_1x        = hga[0];
    for (int t = 0; t < 600 && idx < 3; t++) begin
      tick();
      if (acc_q.size() > base_a + idx) begin
        idx++;
        if (idx < 3) begin
          sample_data    = hd[idx];
          sample_channel = hch[idx];
          gain_1x        = hga[idx];
        end else begin
          sample_valid = 1'b0;
        end
      end
    end
    sample_valid = 1'b0;
    wait_done(base_f + 3, "stream");
    chk("stream_frames", 32'(frames.size() - base_f), 32'd3);
    chk("stream_accepts", 32'(acc_q.size() - base_a), 32'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("stream_word%0d", i), 32'(frames[base_f + i]), 32'(hex[i]));
    chk("stream_spacing01", 32'(acc_q[base_a + 1] - acc_q[base_a]),     32'd71);
    chk("stream_spacing12", 32'(acc_q[base_a + 2] - acc_q[base_a + 1]), 32'd71);

    // A one-cycle valid pulse while busy is ignored.
    base_f = frames.size();
    base_a = acc_q.size();
    send(24'h5A5, 1'b0, 1'b1);
    repeat (20) tick();
    sample_valid   = 1'b1;
    sample_data    = 12'h0F0;
    sample_channel = 1'b1;
    tick();
    sample_valid   = 1'b0;
    wait_done(base_f + 1, "busy_pulse");
    repeat (80) tick();
    chk("busy_pulse_frames",  32'(frames.size() - base_f), 32'd1);
    chk("busy_pulse_accepts", 32'(acc_q.size() - base_a),  32'd1);
    chk("busy_pulse_word",    32'(frames[$]), 32'h35A5);

    // Reset after the fifth SCK rise abandons the frame without an LDAC pulse.
    base_f = frames.size();
    base_l = ldacfall_q.size();
    send(24'hABC, 1'b1, 1'b1);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (bits == 5) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("midreset_reach_bit5", 32'(ok), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (100) tick();
    chk("midreset_no_frame", 32'(frames.size() - base_f),     32'd0);
    chk("midreset_no_ldac",  32'(ldacfall_q.size() - base_l), 32'd0);
    chk("midreset_ready",    32'(sample_ready), 32'd1);
    send(24'h456, 1'b0, 1'b0);
    wait_done(base_f + 1, "post_reset");
    chk("post_reset_word", 32'(frames[$]),  32'h1456);
    chk("post_reset_bits", 32'(nbits_q[$]), 32'd16);
    chk("post_reset_ldac", 32'(ldacfall_q.size() - base_l), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
